// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD bus arbiter.
// Holds the FSM states, the power-up init ROM and the common command/ASCII codes.
package lcd_pkg;

    typedef enum logic [2:0] {
        StPwrup,
        StInitLoad,
        StSetup,
        StPulse,
        StWait,
        StIdle
    } lcd_state_e;

    typedef enum logic [1:0] {
        WaitCmd,
        WaitInit2,
        WaitClear
    } lcd_wait_e;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_HOME     = 8'h02;
    localparam logic [7:0] CMD_DDRAM0   = 8'h80;

    localparam logic [7:0] CHR_0     = 8'h30;
    localparam logic [7:0] CHR_COLON = 8'h3A;

    localparam int unsigned INIT_LEN = 5;

    // Entry 0 sits in the least significant slot.
    localparam logic [INIT_LEN-1:0][7:0] INIT_CMDS = {
        CMD_CLEAR, CMD_DISP_ON, CMD_ENTRY, CMD_FUNC_SET, CMD_FUNC_SET
    };
    localparam logic [INIT_LEN-1:0][1:0] INIT_WAITS = {
        WaitClear, WaitCmd, WaitCmd, WaitCmd, WaitInit2
    };

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_slow_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-way round-robin grant selection; the winner is the client that did not
// win last time whenever both ask at once.
module lcd_rr_arb2
    import lcd_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

    always_comb begin
        grant_valid = |valid;
        if (valid == 2'b11) begin
            grant_idx = ~last_grant;
        end else begin
            grant_idx = valid[1];
        end
    end

endmodule

// File: rtl/lcd_bus_arbiter.sv
// Owns the HD44780 bus: runs the power-up init sequence, then turns round-robin
// granted client bytes into timed E strobes followed by the execution wait.
module lcd_bus_arbiter
    import lcd_pkg::*;
#(
    parameter int unsigned T_PWRUP = 1000000,
    parameter int unsigned T_INIT2 = 300000,
    parameter int unsigned T_SETUP = 4,
    parameter int unsigned T_PULSE = 12,
    parameter int unsigned T_CMD   = 2000,
    parameter int unsigned T_CLEAR = 85000,
    parameter int unsigned CNT_W   = 21
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_valid,
    input  logic       req_rs0,
    input  logic [7:0] req_data0,
    input  logic       req_rs1,
    input  logic [7:0] req_data1,
    output logic [1:0] req_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    lcd_state_e       state;
    lcd_wait_e        wait_sel;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] wait_last;
    logic [2:0]       init_idx;
    logic             last_grant;
    logic             grant_valid;
    logic             grant_idx;
    logic             sel_rs;
    logic [7:0]       sel_data;
    logic             grant_now;

    lcd_rr_arb2 u_arb (
        .valid       (req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_comb begin
        sel_rs    = grant_idx ? req_rs1 : req_rs0;
        sel_data  = grant_idx ? req_data1 : req_data0;
        grant_now = (state == StIdle) && init_done && grant_valid;
        req_ready = 2'b00;
        if (grant_now) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        case (wait_sel)
            WaitInit2: wait_last = CNT_W'(T_INIT2 - 1);
            WaitClear: wait_last = CNT_W'(T_CLEAR - 1);
            default:   wait_last = CNT_W'(T_CMD - 1);
        endcase
    end

    assign busy   = (state != StIdle);
    assign lcd_rw = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= StPwrup;
            cnt        <= '0;
            init_idx   <= '0;
            wait_sel   <= WaitCmd;
            last_grant <= 1'b1;
            init_done  <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_rs     <= 1'b0;
            lcd_e      <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            unique case (state)
                StPwrup: begin
                    if (cnt == CNT_W'(T_PWRUP - 1)) begin
                        state    <= StInitLoad;
                        cnt      <= '0;
                        init_idx <= '0;
                    end
                end
                StInitLoad: begin
                    lcd_data <= INIT_CMDS[init_idx];
                    lcd_rs   <= 1'b0;
                    wait_sel <= lcd_wait_e'(INIT_WAITS[init_idx]);
                    state    <= StSetup;
                    cnt      <= '0;
                end
                StSetup: begin
                    if (cnt == CNT_W'(T_SETUP - 1)) begin
                        state <= StPulse;
                        lcd_e <= 1'b1;
                        cnt   <= '0;
                    end
                end
                StPulse: begin
                    if (cnt == CNT_W'(T_PULSE - 1)) begin
                        state <= StWait;
                        lcd_e <= 1'b0;
                        cnt   <= '0;
                    end
                end
                StWait: begin
                    if (cnt == wait_last) begin
                        cnt <= '0;
                        if (init_done) begin
                            state <= StIdle;
                        end else if (init_idx == 3'(INIT_LEN - 1)) begin
                            init_done <= 1'b1;
                            state     <= StIdle;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            state    <= StInitLoad;
                        end
                    end
                end
                StIdle: begin
                    cnt <= '0;
                    if (grant_now) begin
                        lcd_rs     <= sel_rs;
                        lcd_data   <= sel_data;
                        wait_sel   <= is_slow_cmd(sel_rs, sel_data) ? WaitClear : WaitCmd;
                        last_grant <= grant_idx;
                        state      <= StSetup;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_arbiter.sv
// Directed bench for lcd_bus_arbiter with shortened timing; expected values are
// hand-computed from the timing parameters below.
module tb_lcd_bus_arbiter;

    localparam int unsigned TPW = 20;
    localparam int unsigned TI2 = 10;
    localparam int unsigned TS  = 2;
    localparam int unsigned TP  = 3;
    localparam int unsigned TC  = 5;
    localparam int unsigned TCL = 15;

    localparam logic [7:0] INIT_DATA [5] = '{8'h38, 8'h38, 8'h06, 8'h0C, 8'h01};
    // Cycles to each E rise: from reset release for entry 0, else from the previous E fall.
    localparam int INIT_GAP [5] = '{TPW + 1 + TS, TI2 + 1 + TS, TC + 1 + TS, TC + 1 + TS,
                                    TC + 1 + TS};

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic       req_rs0;
    logic [7:0] req_data0;
    logic       req_rs1;
    logic [7:0] req_data1;
    logic [1:0] req_ready;
    logic       init_done;
    logic       busy;
    logic [7:0] lcd_data;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;

    int total = 0;
    int bad   = 0;
    int leak  = 0;

    lcd_bus_arbiter #(
        .T_PWRUP (TPW),
        .T_INIT2 (TI2),
        .T_SETUP (TS),
        .T_PULSE (TP),
        .T_CMD   (TC),
        .T_CLEAR (TCL),
        .CNT_W   (21)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rs0   (req_rs0),
        .req_data0 (req_data0),
        .req_rs1   (req_rs1),
        .req_data1 (req_data1),
        .req_ready (req_ready),
        .init_done (init_done),
        .busy      (busy),
        .lcd_data  (lcd_data),
        .lcd_e     (lcd_e),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; sample on the falling edge.
    task automatic step();
        @(negedge clk);
        if (!init_done && req_ready != 2'b00) leak++;
    endtask

    task automatic init_pulse(input string tag, input logic [7:0] d, input int gap);
        int n;
        n = 0;
        while (lcd_e !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check_eq({tag, "_gap"}, n, gap);
        check_eq({tag, "_data"}, lcd_data, d);
        check_eq({tag, "_rs"}, lcd_rs, 1'b0);
        check_eq({tag, "_rw"}, lcd_rw, 1'b0);
        check_eq({tag, "_done"}, init_done, 1'b0);
        n = 0;
        while (lcd_e === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_width"}, n, TP);
    endtask

    // Call at the reset-release point; returns at the cycle init_done is first seen.
    task automatic init_seq(input string tag);
        int n;
        for (int i = 0; i < 5; i++) begin
            init_pulse($sformatf("%s_init%0d", tag, i), INIT_DATA[i], INIT_GAP[i]);
        end
        n = 0;
        while (!init_done && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_done_delay"}, n, TCL);
    endtask

    // Single-client transfer issued while the arbiter is idle.
    task automatic xfer(input string tag, input logic port, input logic rs, input logic [7:0] d,
                        input int post_wait);
        int n;
        if (port) begin
            req_rs1   = rs;
            req_data1 = d;
            req_valid = 2'b10;
        end else begin
            req_rs0   = rs;
            req_data0 = d;
            req_valid = 2'b01;
        end
        #1;
        check_eq({tag, "_ready"}, req_ready, port ? 2'b10 : 2'b01);
        step();
        req_valid = 2'b00;
        n = 1;
        check_eq({tag, "_data"}, lcd_data, d);
        check_eq({tag, "_rs"}, lcd_rs, rs);
        check_eq({tag, "_ready_off"}, req_ready, 2'b00);
        while (lcd_e !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_rise"}, n, TS + 1);
        while (lcd_e === 1'b1 && n < 100) begin
            step();
            n++;
        end
        check_eq({tag, "_fall"}, n, TS + 1 + TP);
        while (busy && n < 200) begin
            step();
            n++;
        end
        check_eq({tag, "_idle"}, n, TS + TP + post_wait + 1);
    endtask

    initial begin
        int n;
        rst_n     = 1'b1;
        req_valid = 2'b00;
        req_rs0   = 1'b0;
        req_data0 = 8'h00;
        req_rs1   = 1'b0;
        req_data1 = 8'h00;
        #2 rst_n = 1'b0;
        repeat (3) step();
        check_eq("rst_e", lcd_e, 1'b0);
        check_eq("rst_rs", lcd_rs, 1'b0);
        check_eq("rst_rw", lcd_rw, 1'b0);
        check_eq("rst_data", lcd_data, 8'h00);
        check_eq("rst_ready", req_ready, 2'b00);
        check_eq("rst_done", init_done, 1'b0);
        check_eq("rst_busy", busy, 1'b1);

        // Power-up init with no requests.
        rst_n = 1'b1;
        init_seq("t1");
        check_eq("t1_busy_idle", busy, 1'b0);

        // Single transfers, including the long-wait commands.
        xfer("t2_p0", 1'b0, 1'b1, 8'h35, TC);
        xfer("t4_p0_home", 1'b0, 1'b0, 8'h02, TCL);
        xfer("t4_p1_clear", 1'b1, 1'b0, 8'h01, TCL);
        xfer("t4_p1_data01", 1'b1, 1'b1, 8'h01, TC);
        xfer("t4_p0_ddram", 1'b0, 1'b0, 8'h80, TC);
        xfer("t4_p1_home3", 1'b1, 1'b0, 8'h03, TCL);

        // Both clients always valid: last winner was port 1, so 0,1,0,1.
        req_rs0   = 1'b1;
        req_data0 = 8'h31;
        req_rs1   = 1'b1;
        req_data1 = 8'h3A;
        req_valid = 2'b11;
        #1;
        n = 0;
        for (int k = 0; k < 4; k++) begin
            while (req_ready == 2'b00 && n < 100) begin
                step();
                n++;
            end
            check_eq($sformatf("t3_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) check_eq($sformatf("t3_spacing%0d", k), n, TS + TP + TC + 1);
            step();
            n = 1;
            check_eq($sformatf("t3_data%0d", k), lcd_data, (k % 2) ? 8'h3A : 8'h31);
        end
        req_valid = 2'b00;
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check_eq("t3_drain", busy, 1'b0);

        // Reset in the middle of an E strobe, with both clients waiting through init.
        req_rs0   = 1'b0;
        req_data0 = 8'h0C;
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        n = 0;
        while (lcd_e !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        step();
        check_eq("t6_e_before_rst", lcd_e, 1'b1);
        req_rs0   = 1'b1;
        req_data0 = 8'h31;
        req_rs1   = 1'b1;
        req_data1 = 8'h3A;
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        check_eq("t6_e_drop", lcd_e, 1'b0);
        check_eq("t6_done_drop", init_done, 1'b0);
        check_eq("t6_busy", busy, 1'b1);
        check_eq("t6_ready", req_ready, 2'b00);
        check_eq("t6_data", lcd_data, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        leak  = 0;
        init_seq("t6");
        check_eq("t5_ready_gated", leak, 0);
        check_eq("t5_first_grant", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check_eq("t5_first_data", lcd_data, 8'h31);
        n = 0;
        while (busy && n < 100) begin
            step();
            n++;
        end
        check_eq("t5_drain", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
